// File: rtl/hid_host.sv
// hid_host: serialises key, mouse, joystick and status requests into HID command frames
// and services the receiver's db9 interrupt.
`timescale 1ns/1ps
module hid_host #(
   parameter int STROBE_GAP     = 2,
   parameter int KEY_FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        key_valid,
   input  logic [7:0]  key_code,
   output logic        key_ready,
   input  logic        mouse_valid,
   input  logic [1:0]  mouse_btns,
   input  logic [7:0]  mouse_dx,
   input  logic [7:0]  mouse_dy,
   input  logic        joy_valid,
   input  logic [7:0]  joy_dev,
   input  logic [7:0]  joy_data,
   output logic        joy_ready,
   input  logic        status_req,
   output logic [15:0] status_id,
   output logic        status_valid,
   output logic        hid_strobe,
   output logic        hid_start,
   output logic [7:0]  hid_data,
   input  logic [7:0]  hid_rdata,
   input  logic        irq,
   output logic        iack,
   output logic [5:0]  db9_state,
   output logic        db9_valid,
   output logic        busy
);
   localparam int AW = $clog2(KEY_FIFO_DEPTH);
   localparam logic [1:0] IDLE = 2'd0, STROBE = 2'd1, GAP = 2'd2, CAPTURE = 2'd3;
   logic [1:0] state, bidx, last, last_n, mbtn;
   logic [3:0] gcnt;
   logic [2:0] cmd, cmd_n;
   logic [7:0] frame [4];
   logic [7:0] fifo [KEY_FIFO_DEPTH];
   logic [7:0] f1, f2, f3, jdev, jdat, mdx, mdy;
   logic [AW:0] wp, rp;
   logic joy_full, mouse_full, stat_pend;
   logic idle, fifo_ne, push, go, sel_irq, sel_key, sel_joy, sel_mouse, sel_stat;

   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {a[7], a} + {b[7], b};
      return (s[8] != s[7]) ? {s[8], {7{~s[8]}}} : s[7:0];
   endfunction

   always_comb begin
      idle       = state == IDLE;
      fifo_ne    = wp != rp;
      key_ready  = !((wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]));
      push       = key_valid && key_ready;
      joy_ready  = !joy_full;
      sel_irq    = idle && irq;
      sel_key    = idle && !irq && fifo_ne;
      sel_joy    = idle && !irq && !fifo_ne && joy_full;
      sel_mouse  = idle && !irq && !fifo_ne && !joy_full && mouse_full;
      sel_stat   = idle && !irq && !fifo_ne && !joy_full && !mouse_full && stat_pend;
      go         = sel_irq || sel_key || sel_joy || sel_mouse || sel_stat;
      cmd_n      = sel_irq ? 3'd4 : sel_key ? 3'd1 : sel_joy ? 3'd3 : sel_mouse ? 3'd2 : 3'd0;
      last_n     = sel_mouse ? 2'd3 : (sel_joy || sel_stat) ? 2'd2 : 2'd1;
      f1         = sel_key ? fifo[rp[AW-1:0]] : sel_joy ? jdev : sel_mouse ? {6'b0, mbtn} : 8'h00;
      f2         = sel_joy ? jdat : sel_mouse ? mdx : 8'h00;
      f3         = sel_mouse ? mdy : 8'h00;
      hid_strobe = state == STROBE;
      hid_start  = hid_strobe && bidx == 2'd0;
      hid_data   = frame[bidx];
      iack       = hid_start && cmd == 3'd4;
      busy       = !idle || go;
   end

   always_ff @(posedge clk) if (push) fifo[wp[AW-1:0]] <= key_code;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         bidx         <= '0;
         last         <= '0;
         gcnt         <= '0;
         cmd          <= '0;
         frame        <= '{default: 8'h00};
         wp           <= '0;
         rp           <= '0;
         joy_full     <= 1'b0;
         mouse_full   <= 1'b0;
         stat_pend    <= 1'b0;
         jdev         <= '0;
         jdat         <= '0;
         mbtn         <= '0;
         mdx          <= '0;
         mdy          <= '0;
         status_id    <= '0;
         status_valid <= 1'b0;
         db9_state    <= '0;
         db9_valid    <= 1'b0;
      end else begin
         status_valid <= 1'b0;
         db9_valid    <= 1'b0;
         wp           <= wp + (AW+1)'(push);
         rp           <= rp + (AW+1)'(sel_key);
         stat_pend    <= status_req || (stat_pend && !sel_stat);
         if (joy_valid && joy_ready) begin
            joy_full <= 1'b1;
            jdev     <= joy_dev;
            jdat     <= joy_data;
         end else if (sel_joy) joy_full <= 1'b0;
         // an event in the cycle its slot is snapshotted starts a fresh slot
         if (mouse_valid) begin
            mouse_full <= 1'b1;
            mbtn       <= mouse_btns;
            mdx        <= (mouse_full && !sel_mouse) ? sat_add(mdx, mouse_dx) : mouse_dx;
            mdy        <= (mouse_full && !sel_mouse) ? sat_add(mdy, mouse_dy) : mouse_dy;
         end else if (sel_mouse) mouse_full <= 1'b0;
         case (state)
            IDLE: if (go) begin
               state <= STROBE;
               bidx  <= '0;
               cmd   <= cmd_n;
               last  <= last_n;
               frame <= '{{5'b0, cmd_n}, f1, f2, f3};
            end
            STROBE: begin
               gcnt  <= '0;
               state <= (STROBE_GAP == 1) ? CAPTURE : GAP;
            end
            GAP: begin
               gcnt <= gcnt + 4'd1;
               if (gcnt == 4'(STROBE_GAP - 2)) state <= CAPTURE;
            end
            default: begin
               if (cmd == 3'd0 && bidx == 2'd1) status_id[15:8] <= hid_rdata;
               if (cmd == 3'd0 && bidx == 2'd2) begin
                  status_id[7:0] <= hid_rdata;
                  status_valid   <= 1'b1;
               end
               if (cmd == 3'd4 && bidx == 2'd1) begin
                  db9_state <= hid_rdata[5:0];
                  db9_valid <= 1'b1;
               end
               if (bidx == last) state <= IDLE;
               else begin
                  bidx  <= bidx + 2'd1;
                  state <= STROBE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_hid_host.sv
// tb_hid_host: randomized and directed stimulus against a cycle-level behavioural model of hid_host.
`timescale 1ns/1ps
module tb_hid_host;
   localparam int G = 2;
   localparam int D = 8;
   logic clk = 1'b0, reset_n = 1'b0;
   logic key_valid = 1'b0, mouse_valid = 1'b0, joy_valid = 1'b0, status_req = 1'b0, irq = 1'b0;
   logic [7:0] key_code = '0, mouse_dx = '0, mouse_dy = '0, joy_dev = '0, joy_data = '0, hid_rdata = '0;
   logic [1:0] mouse_btns = '0;
   logic key_ready, joy_ready, status_valid, hid_strobe, hid_start, iack, db9_valid, busy;
   logic [15:0] status_id;
   logic [7:0] hid_data;
   logic [5:0] db9_state;

   hid_host #(.STROBE_GAP(G), .KEY_FIFO_DEPTH(D)) dut (
      .clk(clk), .reset_n(reset_n),
      .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
      .mouse_valid(mouse_valid), .mouse_btns(mouse_btns), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
      .joy_valid(joy_valid), .joy_dev(joy_dev), .joy_data(joy_data), .joy_ready(joy_ready),
      .status_req(status_req), .status_id(status_id), .status_valid(status_valid),
      .hid_strobe(hid_strobe), .hid_start(hid_start), .hid_data(hid_data), .hid_rdata(hid_rdata),
      .irq(irq), .iack(iack), .db9_state(db9_state), .db9_valid(db9_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, cyc = 0;
   int sv_cnt = 0, dv_cnt = 0, iack_cnt = 0, rx_idx = 0;
   bit saw_full = 0, fixed_resp = 1;
   logic [7:0] iack_data = '0;
   logic [7:0] resp [4] = '{default: 8'h00};
   logic [8:0] seen[$], want[$];
   int seen_t[$];

   // behavioural model: frame in flight as (pos, byte list), sources as queue/slots
   bit active, jfull, mfull, spend;
   int pos, fn;
   logic [7:0] fb [4];
   logic [7:0] fcmd, jdev, jdat, mdx, mdy;
   logic [1:0] mb;
   logic [7:0] kq[$];
   logic [15:0] e_sid;
   logic [5:0] e_db9;
   bit e_sv, e_dv;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit pending();
      return kq.size() != 0 || jfull || mfull || spend;
   endfunction

   function automatic logic [7:0] sat(input logic [7:0] a, input logic [7:0] b);
      int s;
      s = int'($signed(a)) + int'($signed(b));
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      return 8'(s);
   endfunction

   task automatic model_reset();
      active = 0; pos = 0; fn = 0; fcmd = 0;
      kq.delete();
      jfull = 0; mfull = 0; spend = 0;
      e_sid = 0; e_db9 = 0; e_sv = 0; e_dv = 0;
      rx_idx = 0;
   endtask

   task automatic model_edge();
      bit was, kpush, jload;
      int k;
      was   = active;
      kpush = key_valid && kq.size() < D;
      jload = joy_valid && !jfull;
      e_sv = 0;
      e_dv = 0;
      if (was) begin
         if (pos % (G + 1) == 0) begin
            k = pos / (G + 1) - 1;
            if (fcmd == 0 && k == 1) e_sid[15:8] = resp[1];
            if (fcmd == 0 && k == 2) begin e_sid[7:0] = resp[2]; e_sv = 1; end
            if (fcmd == 4 && k == 1) begin e_db9 = resp[1][5:0]; e_dv = 1; end
         end
         if (pos == fn * (G + 1)) active = 0; else pos++;
      end else if (irq || pending()) begin
         if (!fixed_resp) begin resp[1] = 8'($urandom); resp[2] = 8'($urandom); end
         active = 1; pos = 1;
         fb[1] = 0; fb[2] = 0; fb[3] = 0;
         if (irq) begin fcmd = 4; fn = 2; end
         else if (kq.size() != 0) begin fcmd = 1; fn = 2; fb[1] = kq.pop_front(); end
         else if (jfull) begin fcmd = 3; fn = 3; fb[1] = jdev; fb[2] = jdat; jfull = 0; end
         else if (mfull) begin fcmd = 2; fn = 4; fb[1] = {6'b0, mb}; fb[2] = mdx; fb[3] = mdy; mfull = 0; end
         else begin fcmd = 0; fn = 3; spend = 0; end
         fb[0] = fcmd;
      end
      if (kpush) kq.push_back(key_code);
      if (jload) begin jfull = 1; jdev = joy_dev; jdat = joy_data; end
      if (mouse_valid) begin
         mb = mouse_btns;
         mdx = mfull ? sat(mdx, mouse_dx) : mouse_dx;
         mdy = mfull ? sat(mdy, mouse_dy) : mouse_dy;
         mfull = 1;
      end
      if (status_req) spend = 1;
   endtask

   task automatic step();
      int k;
      bit st, strobe_now, drop;
      #1;
      st = active && ((pos - 1) % (G + 1) == 0);
      k  = active ? (pos - 1) / (G + 1) : 0;
      chk("hid_strobe", hid_strobe, st);
      if (st) begin
         chk("hid_start", hid_start, k == 0);
         chk("hid_data", hid_data, fb[k]);
      end
      chk("iack", iack, st && k == 0 && fcmd == 4);
      chk("status_valid", status_valid, e_sv);
      chk("status_id", status_id, e_sid);
      chk("db9_valid", db9_valid, e_dv);
      chk("db9_state", db9_state, e_db9);
      chk("key_ready", key_ready, kq.size() < D);
      chk("joy_ready", joy_ready, !jfull);
      chk("busy", busy, active || irq || pending());
      strobe_now = hid_strobe;
      drop = iack;
      if (hid_strobe) begin
         seen.push_back({hid_start, hid_data});
         seen_t.push_back(cyc);
         rx_idx = hid_start ? 0 : rx_idx + 1;
      end
      if (status_valid) sv_cnt++;
      if (db9_valid) dv_cnt++;
      if (iack) begin iack_cnt++; iack_data = hid_data; end
      if (!key_ready) saw_full = 1;
      @(posedge clk);
      cyc++;
      if (!reset_n) model_reset(); else model_edge();
      #1;
      if (strobe_now) hid_rdata = resp[rx_idx > 3 ? 0 : rx_idx];
      if (drop) irq = 1'b0;
      @(negedge clk);
   endtask

   task automatic quiet();
      key_valid = 0; mouse_valid = 0; joy_valid = 0; status_req = 0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      quiet();
      while ((active || pending() || irq) && n < 400) begin step(); n++; end
      chk({name, "_drain"}, n < 400, 1);
      step();
   endtask

   task automatic w(input logic s, input logic [7:0] d);
      want.push_back({s, d});
   endtask

   task automatic check_seq(input string name);
      chk({name, "_len"}, seen.size(), want.size());
      for (int i = 0; i < want.size() && i < seen.size(); i++)
         chk($sformatf("%s_byte%0d", name, i), seen[i], want[i]);
      seen.delete(); want.delete(); seen_t.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int pushed, n;
      bit acc;
      model_reset();
      @(negedge clk);
      chk("rst_strobe", hid_strobe, 0);
      chk("rst_start", hid_start, 0);
      chk("rst_data", hid_data, 0);
      chk("rst_iack", iack, 0);
      chk("rst_key_ready", key_ready, 1);
      chk("rst_joy_ready", joy_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_status_id", status_id, 0);
      chk("rst_db9", db9_state, 0);
      chk("rst_pulses", {status_valid, db9_valid}, 0);
      reset_n = 1;

      key_valid = 1; key_code = 8'h9A;
      step();
      drain("key9a");
      if (seen_t.size() >= 2) chk("key_gap", seen_t[1] - seen_t[0], G + 1);
      w(1, 8'h01); w(0, 8'h9A);
      check_seq("key9a");

      mouse_valid = 1; mouse_btns = 2'd1; mouse_dx = 8'h03; mouse_dy = 8'h04;
      step();
      quiet();
      pushed = 0; n = 0; saw_full = 0;
      while (pushed < 9 && n < 200) begin
         key_valid = 1; key_code = 8'h40 + 8'(pushed);
         acc = kq.size() < D;
         step();
         if (acc) pushed++;
         n++;
      end
      chk("fifo_pushes", pushed, 9);
      drain("fifo");
      chk("fifo_full_seen", saw_full, 1);
      w(1, 8'h02); w(0, 8'h01); w(0, 8'h03); w(0, 8'h04);
      for (int i = 0; i < 9; i++) begin w(1, 8'h01); w(0, 8'h40 + 8'(i)); end
      check_seq("fifo");

      key_valid = 1; key_code = 8'h11; step(); quiet();
      mouse_valid = 1; mouse_btns = 2'd2; mouse_dx = 8'd100; mouse_dy = 8'd5; step();
      mouse_dx = 8'd100; mouse_dy = 8'hFD; step();
      drain("msat_pos");
      w(1, 8'h01); w(0, 8'h11); w(1, 8'h02); w(0, 8'h02); w(0, 8'h7F); w(0, 8'h02);
      check_seq("msat_pos");
      key_valid = 1; key_code = 8'h12; step(); quiet();
      mouse_valid = 1; mouse_btns = 2'd0; mouse_dx = 8'h9C; mouse_dy = 8'h00; step();
      step();
      drain("msat_neg");
      w(1, 8'h01); w(0, 8'h12); w(1, 8'h02); w(0, 8'h00); w(0, 8'h80); w(0, 8'h00);
      check_seq("msat_neg");

      joy_valid = 1; joy_dev = 8'h80; joy_data = 8'h1F; step(); quiet();
      step(); step();
      resp[1] = 8'h2A; dv_cnt = 0; iack_cnt = 0;
      irq = 1;
      drain("irq");
      w(1, 8'h03); w(0, 8'h80); w(0, 8'h1F); w(1, 8'h04); w(0, 8'h00);
      check_seq("irq");
      chk("db9_literal", db9_state, 6'h2A);
      chk("db9_pulses", dv_cnt, 1);
      chk("iack_count", iack_cnt, 1);
      chk("iack_on_cmd4", iack_data, 8'h04);

      resp[1] = 8'h5C; resp[2] = 8'h42; sv_cnt = 0;
      status_req = 1; step(); quiet();
      drain("status");
      w(1, 8'h00); w(0, 8'h00); w(0, 8'h00);
      check_seq("status");
      chk("status_literal", status_id, 16'h5C42);
      chk("status_pulses", sv_cnt, 1);

      mouse_valid = 1; mouse_btns = 2'd1; mouse_dx = 8'h33; mouse_dy = 8'h44; status_req = 1;
      step(); quiet();
      n = 0;
      while (!(active && fcmd == 2 && pos == 1 + 2 * (G + 1)) && n < 50) begin step(); n++; end
      chk("dx_reached", n < 50, 1);
      #1;
      chk("dx_strobe", hid_strobe, 1);
      chk("dx_data", hid_data, 8'h33);
      reset_n = 0;
      #1;
      chk("abort_strobe", hid_strobe, 0);
      chk("abort_busy", busy, 0);
      model_reset();
      seen.delete(); seen_t.delete();
      step(); step();
      reset_n = 1;
      key_valid = 1; key_code = 8'h21; step();
      drain("after_reset");
      w(1, 8'h01); w(0, 8'h21);
      check_seq("after_reset");

      fixed_resp = 0;
      for (int i = 0; i < 3000; i++) begin
         key_valid   = $urandom_range(3) == 0;
         key_code    = 8'($urandom);
         mouse_valid = $urandom_range(7) == 0;
         mouse_btns  = 2'($urandom);
         mouse_dx    = 8'($urandom);
         mouse_dy    = 8'($urandom);
         joy_valid   = $urandom_range(7) == 0;
         joy_dev     = ($urandom_range(2) == 0) ? 8'h00 : ($urandom_range(1) == 0) ? 8'h01 : 8'h80;
         joy_data    = 8'($urandom);
         status_req  = $urandom_range(15) == 0;
         if (!irq && $urandom_range(99) == 0) irq = 1;
         step();
      end
      drain("random");
      seen.delete(); seen_t.delete();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/hid_host.md
Name: hid_host

Overview:
- Initiator-side driver of the HID byte-stream protocol: serialises local keyboard, mouse, joystick and status-poll requests into command frames (start byte plus payload bytes) for the c64 HID receiver.
- Services the receiver's db9 interrupt by issuing the db9 read command and acknowledging it.
- Used in MCU-less builds and as the bench driver for the HID receiver.

Parameters:
- STROBE_GAP, 2, idle cycles after every strobe before the next strobe or capture (legal range 1..15).
- KEY_FIFO_DEPTH, 8, key event FIFO entries (power of two, 2..16).

Ports:
- clk  in  1  core clock
- reset_n  in  1  reset; asynchronous assert, active-low
- key_valid  in  1  key event offered
- key_code  in  8  bit7 = 1 released / 0 pressed, [5:3] column bit, [2:0] row
- key_ready  out  1  FIFO not full
- mouse_valid  in  1  mouse event (always accepted)
- mouse_btns  in  2  button state
- mouse_dx  in  8  signed delta
- mouse_dy  in  8  signed delta
- joy_valid  in  1  joystick event offered
- joy_dev  in  8  device id (0, 1, 0x80)
- joy_data  in  8  joystick bits
- joy_ready  out  1  joystick slot empty
- status_req  in  1  one-cycle pulse: request status read
- status_id  out  16  last status bytes {first, second}
- status_valid  out  1  one-cycle pulse when status_id updates
- hid_strobe  out  1  byte strobe to receiver (one cycle per byte)
- hid_start  out  1  asserted with strobe on command byte only
- hid_data  out  8  byte to receiver
- hid_rdata  in  8  receiver data_out; registered, valid one cycle after strobe
- irq  in  1  receiver db9 interrupt, level
- iack  out  1  one-cycle interrupt acknowledge
- db9_state  out  6  last db9 value read
- db9_valid  out  1  one-cycle pulse when db9_state updates
- busy  out  1  frame in progress

Behaviour:
- Reset values: all strobes and pulses 0; hid_data 0; status_id 0; db9_state 0; FIFO empty; slots empty; key_ready 1; joy_ready 1; busy 0. Asserting reset_n mid-frame aborts the frame immediately with the strobe dropped. The receiver resynchronises on the next start byte.
- FSM states: IDLE, STROBE, GAP, CAPTURE.
- IDLE: selects a frame by fixed priority: irq (CMD 4) > key FIFO non-empty (CMD 1) > joystick slot (CMD 3) > mouse pending (CMD 2) > status pending (CMD 0).
  - The chosen source is snapshotted and its slot freed in the selection cycle.
  - The first STROBE follows on the next cycle. busy is 1 from selection until the last GAP ends.
- Frame byte sequences (command byte first):
  - CMD0: 00, 00, 00
  - CMD1: 01, key_code
  - CMD2: 02, {6'b0, btns}, dx, dy
  - CMD3: 03, dev, data
  - CMD4: 04, 00
- STROBE: hid_strobe = 1 for exactly one cycle, with hid_data stable. hid_start = 1 only on the command byte. Then GAP holds STROBE_GAP cycles.
- CAPTURE: occurs in the last GAP cycle after specific payload strobes.
  - CMD0: after payload 1, capture status_id[15:8]; after payload 2, capture status_id[7:0]. status_valid pulses on the second capture.
  - CMD4: after payload 1, db9_state <= hid_rdata[5:0], db9_valid pulses.
- iack pulses one cycle coincident with the CMD4 start strobe. irq is not re-evaluated until the frame ends.
- Between frames: at least one IDLE cycle.
- Key FIFO:
  - Push on key_valid && key_ready; pop at CMD1 selection.
  - Push and pop in the same cycle are both honoured. Full: key_ready = 0. Pointers wrap modulo depth.
- Joystick slot: load on joy_valid && joy_ready. Cleared at selection, so joy_ready returns the cycle after selection.
- Mouse pending slot:
  - mouse_valid into an empty slot loads btns, dx and dy.
  - mouse_valid into a full slot overwrites btns and adds dx and dy as signed 8-bit saturating to -128..127.
  - Event in the same cycle as selection: the snapshot takes the old slot and the event loads the fresh empty slot.
- status_req: sets a pending flag; multiple requests before service collapse into one.

Test Plan:
- Reset, key_code 0x9A pushed: strobes 01 (start = 1) then 9A (start = 0), spaced STROBE_GAP + 1 cycles; key_ready stays 1.
- Push 9 keys back-to-back with depth 8: key_ready drops after 8 accepted (first is popped at selection, so the 9th accepts when space frees); 9 CMD1 frames emitted in order.
- Mouse dx +100 then +100 before service: frame 02, btns, 7F (saturated), dy; dx -100, -100 yields 80.
- Raise irq while a CMD3 frame is in flight, with receiver model returning 0x2A: the CMD3 frame completes, then CMD4 with iack on its start strobe; db9_state = 0x2A, db9_valid pulse.
- status_req with receiver model returning 5C then 42: status_id = 0x5C42, status_valid single pulse.
- Drop reset_n during the CMD2 dx byte: strobe 0 immediately, pending state cleared; after release a new key frame begins with start = 1.
